// File: rtl/neopix_pkg.sv
// Shared constants and types for the dual-channel SPI-to-WS2812 bridge.
// Holds the WS2812 bit timing, the channel FSM states and the DE0 GPIO pin map.
package neopix_pkg;

   localparam int MAX_BYTES = 192;
   localparam int NUM_CH    = 2;

   // WS2812 timing in CLOCK_50 cycles
   localparam int T0H    = 20;
   localparam int T1H    = 40;
   localparam int TBIT   = 63;
   localparam int TLATCH = 3000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SENDING = 2'd1,
      LATCH   = 2'd2
   } chan_state_t;

   localparam int GPIO_MISO  = 0;
   localparam int GPIO_SSEL0 = 1;
   localparam int GPIO_SSEL1 = 2;
   localparam int GPIO_DO0   = 3;
   localparam int GPIO_DO1   = 4;

endpackage

// File: rtl/neopix_channel.sv
// One WS2812 output channel: frame buffer written from the SPI side, byte counter,
// and an IDLE/SENDING/LATCH serializer that replays the frame with WS2812 timing.
module neopix_channel
   import neopix_pkg::*;
#(
   parameter int DEPTH = MAX_BYTES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sel_fall,
   input  logic       sel_rise,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       dout
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TBIT);
   localparam int LW = $clog2(TLATCH);

   chan_state_t state_reg, state_next;

   logic [7:0]    mem [DEPTH];
   logic [7:0]    rd_data_reg;
   logic [CW-1:0] rd_addr;

   logic [CW-1:0] count_reg;
   logic [CW-1:0] byte_idx_reg;
   logic          accept_reg;
   logic [TW-1:0] tick_reg;
   logic [2:0]    bit_idx_reg;
   logic [7:0]    shift_reg;
   logic [LW-1:0] latch_cnt_reg;
   logic          do_reg, do_next;

   logic wr_ok, bit_end, frame_end, start;

   assign wr_ok     = wr_en && accept_reg && (count_reg < CW'(DEPTH));
   assign bit_end   = (tick_reg == TW'(TBIT - 1));
   assign frame_end = bit_end && (bit_idx_reg == 3'd7) && (byte_idx_reg == count_reg - 1'b1);
   assign start     = sel_rise && accept_reg && (count_reg != '0);

   // The next byte is always being read so the serializer never waits on the RAM;
   // in IDLE the read port sits on byte 0 ready for the frame start.
   always_comb begin
      rd_addr = '0;
      if (state_reg == SENDING && (byte_idx_reg + 1'b1) < count_reg)
         rd_addr = byte_idx_reg + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[count_reg[AW-1:0]] <= wr_data;
      rd_data_reg <= mem[rd_addr[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (start) state_next = SENDING;
         SENDING: if (frame_end) state_next = LATCH;
         LATCH:   if (latch_cnt_reg == LW'(TLATCH - 1)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      do_next = 1'b0;
      if (state_reg == SENDING)
         do_next = tick_reg < (shift_reg[7] ? TW'(T1H) : TW'(T0H));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg     <= '0;
         accept_reg    <= 1'b0;
         byte_idx_reg  <= '0;
         tick_reg      <= '0;
         bit_idx_reg   <= '0;
         shift_reg     <= '0;
         latch_cnt_reg <= '0;
         do_reg        <= 1'b0;
      end else begin
         do_reg <= do_next;

         // A transaction opened while busy never gets accept_reg, so it cannot touch the frame
         if (sel_fall && state_reg == IDLE) begin
            accept_reg <= 1'b1;
            count_reg  <= '0;
         end else begin
            if (sel_rise)
               accept_reg <= 1'b0;
            if (wr_ok)
               count_reg <= count_reg + 1'b1;
         end

         case (state_reg)
            IDLE: begin
               if (start) begin
                  shift_reg    <= rd_data_reg;
                  tick_reg     <= '0;
                  bit_idx_reg  <= '0;
                  byte_idx_reg <= '0;
               end
            end
            SENDING: begin
               latch_cnt_reg <= '0;
               if (bit_end) begin
                  tick_reg    <= '0;
                  bit_idx_reg <= bit_idx_reg + 1'b1;
                  if (bit_idx_reg == 3'd7) begin
                     byte_idx_reg <= byte_idx_reg + 1'b1;
                     shift_reg    <= rd_data_reg;
                  end else begin
                     shift_reg <= {shift_reg[6:0], 1'b0};
                  end
               end else begin
                  tick_reg <= tick_reg + 1'b1;
               end
            end
            LATCH: latch_cnt_reg <= latch_cnt_reg + 1'b1;
            default: ;
         endcase
      end
   end

   assign dout = do_reg;

endmodule

// File: rtl/de0_spi_neopix_top.sv
// DE0 board top: receive-only SPI slave with two chip selects feeding two
// independent WS2812 channels on GPIO_0.
module de0_spi_neopix_top
   import neopix_pkg::*;
#(
   parameter int BUF_BYTES = MAX_BYTES
) (
   input  logic        CLOCK_50,
   input  logic [1:0]  KEY,
   input  logic [1:0]  GPIO_0_IN,
   inout  wire  [33:0] GPIO_0
);

   logic clk, rst_n;
   assign clk   = CLOCK_50;
   assign rst_n = KEY[0];

   // Synchronizer bit order: {ssel1, ssel0, mosi, sck}; chip selects idle high
   localparam logic [3:0] SYNC_IDLE = 4'b1100;

   logic [3:0] raw_in;
   logic [3:0] sync1_reg, sync2_reg, sync3_reg;

   assign raw_in = {GPIO_0[GPIO_SSEL1], GPIO_0[GPIO_SSEL0], GPIO_0_IN[1], GPIO_0_IN[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= SYNC_IDLE;
         sync2_reg <= SYNC_IDLE;
         sync3_reg <= SYNC_IDLE;
      end else begin
         sync1_reg <= raw_in;
         sync2_reg <= sync1_reg;
         sync3_reg <= sync2_reg;
      end
   end

   logic       sck_rise, mosi_s, sel_valid, sel_ch, miso_en;
   logic [1:0] ssel_s, ssel_d, sel_fall, sel_rise;

   assign sck_rise  = sync2_reg[0] & ~sync3_reg[0];
   assign mosi_s    = sync2_reg[1];
   assign ssel_s    = sync2_reg[3:2];
   assign ssel_d    = sync3_reg[3:2];
   assign sel_fall  = ssel_d & ~ssel_s;
   assign sel_rise  = ~ssel_d & ssel_s;
   assign sel_valid = ssel_s[0] ^ ssel_s[1];
   assign sel_ch    = ssel_s[0];
   assign miso_en   = ~&ssel_s;

   logic [7:0] shift_reg;
   logic [2:0] bit_cnt_reg;
   logic [1:0] wr_en_reg;
   logic [7:0] wr_data_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         wr_en_reg   <= '0;
         wr_data_reg <= '0;
      end else begin
         wr_en_reg <= '0;
         // Any chip-select edge restarts byte framing, which also drops a trailing partial byte
         if (|sel_fall || |sel_rise) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
         end else if (sck_rise && sel_valid) begin
            shift_reg   <= {shift_reg[6:0], mosi_s};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 3'd7) begin
               wr_en_reg   <= sel_ch ? 2'b10 : 2'b01;
               wr_data_reg <= {shift_reg[6:0], mosi_s};
            end
         end
      end
   end

   logic [NUM_CH-1:0] pix_out;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      neopix_channel #(
         .DEPTH(BUF_BYTES)
      ) u_channel (
         .clk      (clk),
         .rst_n    (rst_n),
         .sel_fall (sel_fall[gi]),
         .sel_rise (sel_rise[gi]),
         .wr_en    (wr_en_reg[gi]),
         .wr_data  (wr_data_reg),
         .dout     (pix_out[gi])
      );
   end

   assign GPIO_0[GPIO_MISO] = miso_en ? 1'b0 : 1'bz;
   assign GPIO_0[GPIO_DO0]  = pix_out[0];
   assign GPIO_0[GPIO_DO1]  = pix_out[1];

   logic unused_pins;
   assign unused_pins = ^{KEY[1], GPIO_0[33:5]};

endmodule

// File: tb/tb_de0_spi_neopix_top.sv
// Directed and randomized bench for de0_spi_neopix_top: SPI frames in, DO pulse trains
// measured on both channels and compared with a bit-list model of the WS2812 stream.
module tb_de0_spi_neopix_top;

   localparam int MAXB   = 12;
   localparam int T0     = 20;
   localparam int T1     = 40;
   localparam int PERIOD = 63;
   localparam int TL     = 3000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sck = 1'b0, mosi = 1'b0, ssel0 = 1'b1, ssel1 = 1'b1;
   logic [1:0] key, gin;
   wire  [33:0] gpio;

   assign key     = {1'b1, rst_n};
   assign gin     = {mosi, sck};
   assign gpio[1] = ssel0;
   assign gpio[2] = ssel1;
   pullup (gpio[0]);

   always #10 clk = ~clk;

   de0_spi_neopix_top #(.BUF_BYTES(MAXB)) dut (
      .CLOCK_50  (clk),
      .KEY       (key),
      .GPIO_0_IN (gin),
      .GPIO_0    (gpio)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: rise times and high widths per channel, sampled on the falling edge
   int   w0[$], r0[$], w1[$], r1[$];
   int   rise_t[2];
   logic [1:0] prev = 2'b00;
   always @(negedge clk) begin
      logic [1:0] d;
      d = {gpio[4], gpio[3]};
      for (int c = 0; c < 2; c++) begin
         if (d[c] && !prev[c]) begin
            rise_t[c] = cyc;
            if (c == 0) r0.push_back(cyc); else r1.push_back(cyc);
         end
         if (!d[c] && prev[c]) begin
            if (c == 0) w0.push_back(cyc - rise_t[c]); else w1.push_back(cyc - rise_t[c]);
         end
      end
      prev = d;
   end

   int errors = 0;
   int checks = 0;
   logic [7:0] tx_q[$];
   int exp_w[$];
   int raise_cyc;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      w0.delete(); r0.delete(); w1.delete(); r1.delete();
   endtask

   // Reference: each stored byte becomes 8 high widths, MSB first; bytes past MAXB are lost
   task automatic build_expected();
      exp_w.delete();
      for (int i = 0; i < tx_q.size() && i < MAXB; i++)
         for (int b = 7; b >= 0; b--)
            exp_w.push_back(tx_q[i][b] ? T1 : T0);
   endtask

   task automatic spi_bits(input logic [7:0] b, input int nbits, input int half);
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = b[i];
         repeat (half) @(negedge clk);
         sck = 1'b1;
         repeat (half) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   task automatic send_frame(input int mask, input int half);
      sck = 1'b0;
      mosi = 1'b0;
      if (mask[0]) ssel0 = 1'b0;
      if (mask[1]) ssel1 = 1'b0;
      repeat (6) @(negedge clk);
      check("miso_driven_low", int'(gpio[0]), 0);
      foreach (tx_q[i]) spi_bits(tx_q[i], 8, half);
      repeat (half) @(negedge clk);
      ssel0 = 1'b1;
      ssel1 = 1'b1;
      raise_cyc = cyc;
      repeat (4) @(negedge clk);
      check("miso_released", int'(gpio[0]), 1);
   endtask

   task automatic wait_frame();
      int target;
      target = raise_cyc + exp_w.size() * PERIOD + 30;
      while (cyc < target) @(negedge clk);
   endtask

   task automatic check_frame(input int ch);
      int got_w[$], got_r[$];
      int other, ok, lat;
      if (ch == 0) begin
         got_w = w0; got_r = r0; other = w1.size() + r1.size();
      end else begin
         got_w = w1; got_r = r1; other = w0.size() + r0.size();
      end
      $display("txn ch=%0d bytes=%0d bits_expected=%0d bits_seen=%0d", ch, tx_q.size(),
               exp_w.size(), got_w.size());
      check($sformatf("ch%0d_nbits", ch), got_w.size(), exp_w.size());
      ok = 0;
      for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
         if (got_w[i] == exp_w[i]) ok++;
      check($sformatf("ch%0d_high_widths", ch), ok, exp_w.size());
      ok = 0;
      for (int i = 1; i < got_r.size(); i++)
         if (got_r[i] - got_r[i-1] == PERIOD) ok++;
      check($sformatf("ch%0d_bit_periods", ch), ok, exp_w.size() - 1);
      lat = (got_r.size() > 0) ? got_r[0] - raise_cyc : -1;
      checks++;
      assert (lat >= 2 && lat <= 7) else begin
         errors++;
         $error("FAIL ch%0d_start_latency: observed=%0d expected=2..7", ch, lat);
      end
      check($sformatf("ch%0d_other_silent", ch), other, 0);
   endtask

   initial begin
      int first_raise, n, ch;
      logic [7:0] b;

      // Reset hold
      rst_n = 1'b0;
      repeat (50) @(negedge clk);
      check("reset_do0", int'(gpio[3]), 0);
      check("reset_do1", int'(gpio[4]), 0);
      check("reset_miso_z", int'(gpio[0]), 1);
      check("reset_no_pulses", r0.size() + r1.size(), 0);
      $display("txn reset hold");
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // Channel 0 frame at 500 kHz SCK
      clear_mon();
      tx_q = '{8'hAA, 8'h55, 8'h00, 8'hAA, 8'h55, 8'h00};
      build_expected();
      send_frame(1, 50);
      wait_frame();
      check_frame(0);
      repeat (TL) @(negedge clk);

      // Channel 1 frame, same data
      clear_mon();
      send_frame(2, 8);
      wait_frame();
      check_frame(1);
      repeat (TL) @(negedge clk);

      // Short frame
      clear_mon();
      tx_q = '{8'h00, 8'h55, 8'hAA};
      build_expected();
      send_frame(1, 8);
      wait_frame();
      check_frame(0);
      repeat (TL) @(negedge clk);

      // New transaction while SENDING is ignored
      clear_mon();
      tx_q.delete();
      for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom));
      build_expected();
      send_frame(1, 8);
      first_raise = raise_cyc;
      repeat (10 * PERIOD) @(negedge clk);
      tx_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      send_frame(1, 8);
      raise_cyc = first_raise;
      wait_frame();
      check_frame(0);

      // New transaction while in LATCH is ignored
      clear_mon();
      tx_q = '{8'hF0};
      send_frame(1, 8);
      repeat (300) @(negedge clk);
      $display("txn ch=0 during latch pulses_seen=%0d", r0.size());
      check("latch_ignores_txn", r0.size() + r1.size(), 0);
      repeat (TL) @(negedge clk);

      // Five bits only: no byte stored, no output
      clear_mon();
      ssel0 = 1'b0;
      repeat (6) @(negedge clk);
      spi_bits(8'hFF, 5, 8);
      repeat (8) @(negedge clk);
      ssel0 = 1'b1;
      repeat (300) @(negedge clk);
      $display("txn ch=0 five bits pulses_seen=%0d", r0.size());
      check("partial_byte_no_output", r0.size() + r1.size(), 0);

      // Both selects low: bytes discarded
      clear_mon();
      tx_q = '{8'hC3, 8'h3C};
      send_frame(3, 8);
      repeat (300) @(negedge clk);
      $display("txn both selects pulses_seen=%0d", r0.size() + r1.size());
      check("both_ssel_no_output", r0.size() + r1.size(), 0);

      // Randomized frames
      for (int it = 0; it < 3; it++) begin
         clear_mon();
         ch = int'($urandom_range(0, 1));
         n  = int'($urandom_range(1, 5));
         tx_q.delete();
         for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
         build_expected();
         send_frame(ch + 1, 8);
         wait_frame();
         check_frame(ch);
         repeat (TL) @(negedge clk);
      end

      // Overflow: four bytes past the buffer depth at the fastest SCK
      clear_mon();
      tx_q.delete();
      for (int i = 0; i < MAXB + 4; i++) tx_q.push_back(8'($urandom));
      build_expected();
      send_frame(2, 4);
      wait_frame();
      check_frame(1);
      repeat (TL) @(negedge clk);

      // Reset mid-frame
      clear_mon();
      tx_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      send_frame(1, 8);
      repeat (10 * PERIOD) @(negedge clk);
      n = 0;
      while (gpio[3] !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("do0_high_before_reset", int'(gpio[3]), 1);
      #1 rst_n = 1'b0;
      #1 check("reset_drops_do0", int'(gpio[3]), 0);
      $display("txn ch=0 reset mid-frame");
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      clear_mon();
      repeat (800) @(negedge clk);
      check("no_resume_after_reset", r0.size() + r1.size(), 0);

      // Channel is IDLE again and accepts a fresh frame
      clear_mon();
      tx_q = '{8'($urandom), 8'($urandom)};
      build_expected();
      send_frame(1, 8);
      wait_frame();
      check_frame(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
